// File: rtl/oldland_dbus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter: state encoding and master indices.
// Also used by the round-robin picker so a future instruction-bus arbiter can reuse both.
package oldland_dbus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  function automatic logic other_master(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/oldland_dbus_arbiter_if.sv
// One word-addressed data-bus port. The requester drives the master modport;
// whoever answers the request uses the slave modport.
interface oldland_dbus_arbiter_if;

  logic        access;
  logic        wr_en;
  logic [29:0] addr;
  logic [3:0]  bytesel;
  logic [31:0] wr_val;
  logic [31:0] data;
  logic        ack;
  logic        error;

  modport master (
    output access, wr_en, addr, bytesel, wr_val,
    input  data, ack, error
  );

  modport slave (
    input  access, wr_en, addr, bytesel, wr_val,
    output data, ack, error
  );

endinterface

// File: rtl/oldland_rr_pick2.sv
// Combinational two-request round-robin picker: on a tie the master that was
// not granted last wins, otherwise the lone requester is chosen.
module oldland_rr_pick2
  import oldland_dbus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = M_CPU;
    if (req0 && req1) begin
      gnt_idx = other_master(last_grant);
    end else if (req1) begin
      gnt_idx = M_AUX;
    end
  end

endmodule

// File: rtl/oldland_dbus_arbiter.sv
// Two-master data-bus arbiter: grants one master at a time, holds the grant until
// ack/error or withdrawal, and synthesizes an error if the slave never answers.
module oldland_dbus_arbiter
  import oldland_dbus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  oldland_dbus_arbiter_if.slave  m0,
  oldland_dbus_arbiter_if.slave  m1,
  oldland_dbus_arbiter_if.master d,
  output logic                   busy,
  output logic                   owner
);

  localparam bit                    TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] CNT_MAX  = '1;

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;

  logic        pick_valid;
  logic        pick_idx;
  logic        o_access;
  logic        o_wr_en;
  logic [29:0] o_addr;
  logic [3:0]  o_bytesel;
  logic [31:0] o_wr_val;
  logic        active;
  logic        resp;
  logic        timeout_hit;
  logic        done;
  logic        sel0;
  logic        sel1;

  oldland_rr_pick2 u_pick (
    .req0       (m0.access),
    .req1       (m1.access),
    .last_grant (last_grant_q),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    if (owner_q == M_AUX) begin
      o_access  = m1.access;
      o_wr_en   = m1.wr_en;
      o_addr    = m1.addr;
      o_bytesel = m1.bytesel;
      o_wr_val  = m1.wr_val;
    end else begin
      o_access  = m0.access;
      o_wr_en   = m0.wr_en;
      o_addr    = m0.addr;
      o_bytesel = m0.bytesel;
      o_wr_val  = m0.wr_val;
    end
  end

  // Gating with rst drops the grant in the reset cycle itself, so a late
  // response can never reach a master.
  assign active      = (state_q == ST_BUSY) && !rst;
  assign resp        = d.ack | d.error;
  assign timeout_hit = TIMEOUT_EN && active && o_access && !resp && (cnt_q == CNT_LAST);
  assign done        = resp | timeout_hit | !o_access;
  assign sel0        = active && (owner_q == M_CPU);
  assign sel1        = active && (owner_q == M_AUX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= M_CPU;
      last_grant_q <= M_AUX;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_BUSY;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d      = ST_IDLE;
          last_grant_d = owner_q;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + TIMEOUT_BITS'(1);
        end
      end
    endcase
  end

  always_comb begin
    d.access  = active & o_access & ~timeout_hit;
    d.wr_en   = active & o_wr_en;
    d.addr    = active ? o_addr    : '0;
    d.bytesel = active ? o_bytesel : '0;
    d.wr_val  = active ? o_wr_val  : '0;

    m0.ack    = sel0 & d.ack;
    m0.error  = sel0 & (d.error | timeout_hit);
    m0.data   = sel0 ? d.data : '0;

    m1.ack    = sel1 & d.ack;
    m1.error  = sel1 & (d.error | timeout_hit);
    m1.data   = sel1 ? d.data : '0;

    busy      = (state_q == ST_BUSY);
    owner     = owner_q;
  end

endmodule

// File: tb/tb_oldland_dbus_arbiter.sv
// Bench for oldland_dbus_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_oldland_dbus_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic owner;

  oldland_dbus_arbiter_if m0_if ();
  oldland_dbus_arbiter_if m1_if ();
  oldland_dbus_arbiter_if d_if ();

  oldland_dbus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_BITS   (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .d     (d_if),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // stimulus
  logic        s_rst;
  logic        s_acc[2];
  logic        s_wr[2];
  logic [29:0] s_addr[2];
  logic [3:0]  s_bs[2];
  logic [31:0] s_wv[2];
  logic        s_dack, s_derr;
  logic [31:0] s_ddata;

  // reference model: which master holds the grant (-1 none), cycles held,
  // who wins the next tie, and the last granted master
  int   g_own = -1;
  int   age   = 0;
  int   pref  = 0;
  int   last_owner = 0;

  logic        exp_ack[2], exp_err[2];
  logic [31:0] exp_data[2];
  logic        exp_d_access, exp_d_wr, exp_busy, exp_owner;
  logic [29:0] exp_d_addr;
  logic [3:0]  exp_d_bs;
  logic [31:0] exp_d_wv;

  logic        obs_ack[2], obs_err[2];
  logic [31:0] obs_data[2];
  logic        obs_d_access, obs_d_wr, obs_busy, obs_owner;
  logic [29:0] obs_d_addr;
  logic [3:0]  obs_d_bs;
  logic [31:0] obs_d_wv;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s @cycle %0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  task automatic cycle();
    logic a, to_hit, fin;
    int   g;
    rst             = s_rst;
    m0_if.access    = s_acc[0];  m1_if.access  = s_acc[1];
    m0_if.wr_en     = s_wr[0];   m1_if.wr_en   = s_wr[1];
    m0_if.addr      = s_addr[0]; m1_if.addr    = s_addr[1];
    m0_if.bytesel   = s_bs[0];   m1_if.bytesel = s_bs[1];
    m0_if.wr_val    = s_wv[0];   m1_if.wr_val  = s_wv[1];
    d_if.ack        = s_dack;
    d_if.error      = s_derr;
    d_if.data       = s_ddata;
    #4;

    exp_d_access = 1'b0; exp_d_wr = 1'b0; exp_d_addr = '0; exp_d_bs = '0; exp_d_wv = '0;
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = 1'b0; exp_err[i] = 1'b0; exp_data[i] = '0;
    end
    exp_busy  = (g_own >= 0);
    exp_owner = 1'(last_owner);
    to_hit = 1'b0;
    fin    = 1'b0;
    if (!s_rst && g_own >= 0) begin
      a      = s_acc[g_own];
      to_hit = (TO > 0) && (age == TO - 1) && a && !s_dack && !s_derr;
      exp_d_access = a && !to_hit;
      exp_d_wr     = s_wr[g_own];
      exp_d_addr   = s_addr[g_own];
      exp_d_bs     = s_bs[g_own];
      exp_d_wv     = s_wv[g_own];
      exp_ack[g_own]  = s_dack;
      exp_err[g_own]  = s_derr | to_hit;
      exp_data[g_own] = s_ddata;
      fin = s_dack | s_derr | to_hit | !a;
    end

    obs_d_access = d_if.access; obs_d_wr = d_if.wr_en; obs_d_addr = d_if.addr;
    obs_d_bs = d_if.bytesel; obs_d_wv = d_if.wr_val;
    obs_ack[0] = m0_if.ack; obs_err[0] = m0_if.error; obs_data[0] = m0_if.data;
    obs_ack[1] = m1_if.ack; obs_err[1] = m1_if.error; obs_data[1] = m1_if.data;
    obs_busy = busy; obs_owner = owner;

    chk_eq("d_access", 32'(obs_d_access), 32'(exp_d_access));
    chk_eq("d_wr_en", 32'(obs_d_wr), 32'(exp_d_wr));
    chk_eq("d_addr", 32'(obs_d_addr), 32'(exp_d_addr));
    chk_eq("d_bytesel", 32'(obs_d_bs), 32'(exp_d_bs));
    chk_eq("d_wr_val", obs_d_wv, exp_d_wv);
    chk_eq("m0_ack", 32'(obs_ack[0]), 32'(exp_ack[0]));
    chk_eq("m0_error", 32'(obs_err[0]), 32'(exp_err[0]));
    chk_eq("m0_data", obs_data[0], exp_data[0]);
    chk_eq("m1_ack", 32'(obs_ack[1]), 32'(exp_ack[1]));
    chk_eq("m1_error", 32'(obs_err[1]), 32'(exp_err[1]));
    chk_eq("m1_data", obs_data[1], exp_data[1]);
    chk_eq("busy", 32'(obs_busy), 32'(exp_busy));
    chk_eq("owner", 32'(obs_owner), 32'(exp_owner));

    if (s_rst) begin
      g_own = -1; last_owner = 0; pref = 0;
    end else if (g_own < 0) begin
      if (s_acc[0] || s_acc[1]) begin
        g = (s_acc[0] && s_acc[1]) ? pref : (s_acc[1] ? 1 : 0);
        g_own = g; last_owner = g; age = 0;
      end
    end else if (fin) begin
      pref  = 1 - g_own;
      g_own = -1;
    end else begin
      age++;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    s_acc[0] = 1'b0; s_acc[1] = 1'b0;
    s_dack = 1'b0; s_derr = 1'b0; s_ddata = 32'h0;
  endtask

  initial begin
    logic pend[2];
    int   lat, kind;
    logic respond;

    s_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_wr[i] = 1'b0; s_addr[i] = '0; s_bs[i] = '0; s_wv[i] = '0; pend[i] = 1'b0;
    end
    idle_inputs();
    lat = 0; kind = 3;
    rst = 1'b1;
    m0_if.access = 1'b0; m1_if.access = 1'b0;
    d_if.ack = 1'b0; d_if.error = 1'b0; d_if.data = '0;
    @(posedge clk);
    #1;

    // reset state
    cycle();
    s_rst = 1'b0;
    cycle();
    chk_eq("rst.owner", 32'(obs_owner), 32'h0);
    chk_eq("rst.busy", 32'(obs_busy), 32'h0);

    // single read with slave answering on the third busy cycle
    s_acc[0] = 1'b1; s_wr[0] = 1'b0; s_addr[0] = 30'h100; s_bs[0] = 4'hF;
    cycle();
    chk_eq("read.no_d_access_idle", 32'(obs_d_access), 32'h0);
    cycle();
    chk_eq("read.d_access", 32'(obs_d_access), 32'h1);
    chk_eq("read.d_addr", 32'(obs_d_addr), 32'h100);
    cycle();
    s_dack = 1'b1; s_ddata = 32'hDEADBEEF;
    cycle();
    chk_eq("read.m0_ack", 32'(obs_ack[0]), 32'h1);
    chk_eq("read.m0_data", obs_data[0], 32'hDEADBEEF);
    chk_eq("read.m1_ack", 32'(obs_ack[1]), 32'h0);
    idle_inputs();
    cycle();
    chk_eq("read.idle_after", 32'(obs_busy), 32'h0);

    // simultaneous requests after reset with a zero-wait slave
    s_rst = 1'b1; cycle(); s_rst = 1'b0;
    s_acc[0] = 1'b1; s_acc[1] = 1'b1; s_dack = 1'b1; s_ddata = 32'h1234_5678;
    cycle();
    cycle();
    chk_eq("rr.first_m0_ack", 32'(obs_ack[0]), 32'h1);
    s_acc[0] = 1'b0;
    cycle();
    chk_eq("rr.bubble", 32'(obs_busy), 32'h0);
    cycle();
    chk_eq("rr.m1_ack", 32'(obs_ack[1]), 32'h1);
    chk_eq("rr.m1_owner", 32'(obs_owner), 32'h1);
    s_acc[0] = 1'b1;
    cycle();
    cycle();
    chk_eq("rr.again_m0_ack", 32'(obs_ack[0]), 32'h1);
    s_acc[0] = 1'b0;
    cycle();
    cycle();
    s_acc[1] = 1'b0; s_dack = 1'b0;
    cycle();

    // write pass-through on master 1
    s_acc[1] = 1'b1; s_wr[1] = 1'b1; s_addr[1] = 30'h3FFFFFFF; s_bs[1] = 4'b0100; s_wv[1] = 32'h00AB0000;
    cycle();
    cycle();
    chk_eq("wr.d_addr", 32'(obs_d_addr), 32'h3FFFFFFF);
    chk_eq("wr.d_bytesel", 32'(obs_d_bs), 32'h4);
    chk_eq("wr.d_wr_val", obs_d_wv, 32'h00AB0000);
    chk_eq("wr.d_wr_en", 32'(obs_d_wr), 32'h1);
    s_dack = 1'b1;
    cycle();
    chk_eq("wr.m1_ack", 32'(obs_ack[1]), 32'h1);
    idle_inputs();
    cycle();

    // slave error then re-arbitration
    s_acc[0] = 1'b1; s_wr[0] = 1'b0; s_addr[0] = 30'h2A0;
    cycle();
    s_derr = 1'b1;
    cycle();
    chk_eq("err.m0_error", 32'(obs_err[0]), 32'h1);
    chk_eq("err.m0_ack", 32'(obs_ack[0]), 32'h0);
    s_acc[0] = 1'b0; s_derr = 1'b0; s_acc[1] = 1'b1;
    cycle();
    chk_eq("err.idle", 32'(obs_busy), 32'h0);
    cycle();
    chk_eq("err.regrant_owner", 32'(obs_owner), 32'h1);
    s_dack = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // timeout with master 1 waiting
    s_acc[0] = 1'b1; s_acc[1] = 1'b1;
    cycle();
    cycle(); cycle(); cycle();
    chk_eq("to.d_access_before", 32'(obs_d_access), 32'h1);
    cycle();
    chk_eq("to.m0_error", 32'(obs_err[0]), 32'h1);
    chk_eq("to.d_access_dropped", 32'(obs_d_access), 32'h0);
    s_acc[0] = 1'b0;
    cycle();
    cycle();
    chk_eq("to.m1_granted", 32'(obs_owner), 32'h1);
    chk_eq("to.m1_busy", 32'(obs_busy), 32'h1);
    s_dack = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // reset in the second busy cycle, then a late ack
    s_acc[0] = 1'b1;
    cycle();
    cycle();
    s_rst = 1'b1;
    cycle();
    chk_eq("rstmid.d_access", 32'(obs_d_access), 32'h0);
    s_rst = 1'b0; idle_inputs(); s_dack = 1'b1; s_ddata = 32'hCAFEF00D;
    cycle();
    chk_eq("rstmid.busy", 32'(obs_busy), 32'h0);
    chk_eq("rstmid.m0_ack", 32'(obs_ack[0]), 32'h0);
    chk_eq("rstmid.m1_ack", 32'(obs_ack[1]), 32'h0);
    idle_inputs();
    cycle();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      s_rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          s_wr[i]   = 1'($urandom_range(0, 1));
          s_addr[i] = 30'($urandom);
          s_bs[i]   = 4'($urandom);
          s_wv[i]   = $urandom;
        end else if (pend[i] && $urandom_range(0, 59) == 0) begin
          pend[i] = 1'b0;
        end
        s_acc[i] = pend[i];
      end
      if (g_own >= 0 && age == 0) begin
        lat  = $urandom_range(0, 5);
        kind = $urandom_range(0, 11);
      end
      respond = (g_own >= 0 && age == lat) || (g_own < 0 && $urandom_range(0, 9) == 0);
      s_dack  = respond && (kind >= 2);
      s_derr  = respond && (kind <= 2);
      s_ddata = $urandom;
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i] || exp_err[i]) pend[i] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/oldland_dbus_arbiter.md
Name: oldland_dbus_arbiter

Overview:
Two-master arbiter for the data bus. Master 0 is the CPU memory stage; master 1 is a secondary requester such as the debug controller or a TLB walker. It owns the single downstream word-addressed data port: it grants one master at a time, holds the grant until ack or error, and enforces a bus timeout that returns an error.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUSY without ack/error before a synthesized error (0 = timeout disabled)
TIMEOUT_BITS, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, single domain
rst  in  1  synchronous active-high reset
m0_access  in  1  master 0 request; held until m0_ack or m0_error
m0_wr_en  in  1  master 0 write
m0_addr  in  30  master 0 word address
m0_bytesel  in  4  master 0 byte enables
m0_wr_val  in  32  master 0 write data
m0_data  out  32  master 0 read data
m0_ack  out  1  master 0 completion
m0_error  out  1  master 0 bus error or timeout
m1_access, m1_wr_en, m1_addr, m1_bytesel, m1_wr_val, m1_data, m1_ack, m1_error: same as m0_*, for master 1
d_access  out  1  downstream request
d_wr_en  out  1  downstream write
d_addr  out  30  downstream word address
d_bytesel  out  4  downstream byte enables
d_wr_val  out  32  downstream write data
d_data  in  32  downstream read data
d_ack  in  1  downstream completion
d_error  in  1  downstream error
busy  out  1  arbiter in BUSY state
owner  out  1  current or last granted master

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, BUSY. The state register, owner, last_grant and timeout counter are registered.
- Reset: state=IDLE, owner=0, last_grant=1 (so master 0 wins the first tie), counter=0.
- Reset effect on outputs: all d_* outputs are 0; m*_ack, m*_error and m*_data are 0.
- Reset mid-transaction: the grant is dropped immediately and no ack is forwarded. The downstream slave must tolerate an abandoned access.
- IDLE with no mN_access: stay in IDLE.
- IDLE with exactly one requester: go to BUSY with owner set to that master.
- IDLE with both requesting: round-robin. Grant the master that is not last_grant.
- Grant latency: a request first seen in cycle N drives d_access in cycle N+1. There is no downstream activity in IDLE.
- BUSY routing: d_access, d_wr_en, d_addr, d_bytesel and d_wr_val are combinational copies of the owner's signals.
- Non-owner gating: the non-owner's ack, error and data outputs are 0.
- Read data: d_data is routed to the owner's mN_data only while BUSY. It is 0 otherwise.
- BUSY and d_ack: assert the owner's ack in the same cycle (combinational). Set last_grant=owner and go to IDLE next cycle. The next grant takes effect one cycle later (one bubble).
- BUSY and d_error: same as d_ack, but asserts the owner's error instead of ack.
- d_ack and d_error together: both are forwarded to the owner. Error takes precedence for the master.
- Owner withdraws access before completion: protocol violation. Drive d_access=0, go to IDLE, and update last_grant.
- Timeout counter: clears on entry to BUSY and increments each BUSY cycle without ack/error.
- Timeout action: when counter==TIMEOUT_CYCLES-1 and no ack/error, assert the owner's error for one cycle and deassert d_access in that cycle. Go to IDLE.
- Counter width: the counter saturates and never wraps. TIMEOUT_CYCLES=0 disables the timeout.
- Status outputs: busy = (state==BUSY); owner is registered.

Decomposition:
- Shared package: state encoding constants (IDLE/BUSY) and master index constants M_CPU=0, M_AUX=1.
- Sub-module oldland_rr_pick2: two-request round-robin picker with a last_grant input. It is combinational and reused by a future instruction-bus arbiter.
- Everything else is inline.

Test Plan:
- Single read: m0 read at 0x100, slave acks after 3 cycles with d_data=0xDEADBEEF -> d_access rises the cycle after the request. m0_ack and m0_data=0xDEADBEEF arrive on the ack cycle. m1_ack stays 0 throughout.
- Simultaneous requests after reset, zero-wait slave -> m0 is served first. m1 is granted on the second cycle after m0_ack (one-bubble gap). A further simultaneous pair is served m0 first again (round-robin, since last_grant=1).
- Write pass-through: m1 write, addr=0x3FFFFFFF, bytesel=4'b0100, wr_val=0x00AB0000 -> d_* match exactly while BUSY. m1_ack follows d_ack.
- Slave error: d_error on a m0 read -> m0_error=1 and m0_ack=0. The arbiter is in IDLE next cycle and re-arbitrates.
- Timeout: TIMEOUT_CYCLES=4 and the slave never responds -> m0_error asserts on the 4th BUSY cycle with d_access=0 in that cycle. A pending m1 request is granted afterwards.
- Reset mid-transfer: rst asserted in the 2nd BUSY cycle -> all outputs are 0 next cycle and the state is IDLE. A late d_ack after reset is not forwarded to either master.
